// File: rtl/apb_master.sv
// apb_master: turns a valid/ready command stream into single APB read/write
// transfers and returns one response per command on a valid/ready channel.
// Only one transfer is outstanding at a time. Every APB and response output
// is registered; cmd_ready is the only combinational output.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYC cycles without PREADY, returning rsp_err=1.
module apb_master #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_W      = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              PCLK,
    input  logic              PRESET,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [WAIT_W-1:0] cfg_wait,
    // APB requester side
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic [WAIT_W-1:0] PWAIT,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    // Reject a timeout limit that cannot be represented at elaboration time.
    if (TIMEOUT_CYC < 1) begin : g_timeout_range_err
        $error("apb_master: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_psel;
    logic                r_penable;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic [WAIT_W-1:0]   r_pwait;

    logic                r_rsp_valid;
    logic                r_rsp_write;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_accept;    // command handshake this cycle
    logic                w_timeout;   // ACCESS abandoned this cycle
    logic                w_xfer_end;  // ACCESS finishes this cycle (ready or timeout)

    // A new command is only taken when idle and the response slot is free
    // (or being drained this very cycle), which allows back-to-back transfers.
    assign cmd_ready  = PRESET & (r_state == ST_IDLE) & (~r_rsp_valid | rsp_ready);
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_xfer_end = (r_state == ST_ACCESS) & (PREADY | w_timeout);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_to_cnt;

    // Count ACCESS cycles spent waiting on PREADY; restart for every transfer.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !PREADY && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // PREADY in the limit cycle wins: the transfer completes normally.
    assign w_timeout = (r_state == ST_ACCESS) & ~PREADY & (r_to_cnt == TO_LIMIT);
`else
    // Base build: ACCESS waits for PREADY indefinitely.
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge PCLK or negedge PRESET) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values, independent of block ordering.
        if (!PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: IDLE -> SETUP on accept, one SETUP cycle, then ACCESS
    // until the slave is ready (or the transfer times out).
    always_comb begin
        // NOTE: the default assignment first means every path drives
        // w_state_nxt, so no latch is inferred.
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (PREADY || w_timeout) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // APB request signals: capture the command on accept, raise PENABLE after
    // SETUP, drop the select when ACCESS ends. Address/data/direction/wait
    // hold their last value between transfers.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pwait   <= '0;
        end else if (w_accept) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_paddr   <= cmd_addr;
            r_pwrite  <= cmd_write;
            r_pwdata  <= cmd_write ? cmd_wdata : '0;
            r_pwait   <= cfg_wait;
        end else if (r_state == ST_SETUP) begin
            r_penable <= 1'b1;
        end else if (w_xfer_end) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end
    end

    // Response register: loading a finished transfer takes priority over
    // clearing on handshake; otherwise contents hold while back-pressured.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_xfer_end) begin
            r_rsp_valid <= 1'b1;
            r_rsp_write <= r_pwrite;
            r_rsp_rdata <= (r_pwrite || w_timeout) ? '0 : PRDATA;
            r_rsp_err   <= w_timeout;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign PWAIT     = r_pwait;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed stimulus with a response scoreboard. Stimulus pushes
// the expected response when it issues a command; a monitor pops and compares
// on every response handshake. APB-phase timing is checked inline.
module tb_apb_master;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int WAIT_W = 4;
    localparam int TO_CYC = 8;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic [WAIT_W-1:0] cfg_wait = '0;
    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [WAIT_W-1:0] PWAIT;
    logic              PREADY = 1'b0;
    logic [DATA_W-1:0] PRDATA = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    apb_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_W(WAIT_W), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cfg_wait(cfg_wait),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PWAIT(PWAIT), .PREADY(PREADY), .PRDATA(PRDATA),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    int   setup_q[$];
    logic psel_at[int];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic w, input logic [DATA_W-1:0] d, input logic e);
        exp_t x;
        x.write = w;
        x.rdata = d;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    // Present a command at the current negedge, wait (bounded) for acceptance,
    // return at the negedge of the SETUP cycle with cmd_valid dropped.
    task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wd, input logic [WAIT_W-1:0] wt);
        int budget;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cfg_wait  = wt;
        #1;
        budget = 0;
        while (!cmd_ready && budget < 50) begin
            @(negedge PCLK);
            #1;
            budget++;
        end
        check("cmd_accept_bound", cmd_ready, 1'b1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge PCLK);
        cyc++;
    end

    // Record SETUP cycles and the PSEL level of every cycle.
    initial forever begin
        @(negedge PCLK);
        psel_at[cyc] = PSEL;
        if (PRESET && PSEL && !PENABLE) setup_q.push_back(cyc);
    end

    // Response monitor: compare each handshaken response with the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge PCLK);
        #1;
        if (PRESET && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got write=%0b rdata=0x%0h err=%0b, expected no response",
                         rsp_write, rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                check("rsp_write", rsp_write, e.write);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
            end
        end
    end

    initial begin
        int n_acc;
        int budget;
        int s0;

        // ---------------- reset state ----------------
        cmd_valid = 1'b1;
        repeat (2) @(negedge PCLK);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_paddr", PADDR, '0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_pwdata", PWDATA, '0);
        check("rst_pwait", PWAIT, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_write", rsp_write, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        check("rst_rsp_err", rsp_err, 1'b0);
        cmd_valid = 1'b0;
        PRESET = 1'b1;
        @(negedge PCLK);

        // ---------------- 1: single write, zero wait ----------------
        PREADY = 1'b1;
        push_exp(1'b1, 32'h0, 1'b0);
        send_cmd(1'b1, 8'h10, 32'hDEADBEEF, 4'd0);
        check("t1_setup_psel", PSEL, 1'b1);
        check("t1_setup_penable", PENABLE, 1'b0);
        check("t1_setup_paddr", PADDR, 8'h10);
        check("t1_setup_pwdata", PWDATA, 32'hDEADBEEF);
        check("t1_setup_pwrite", PWRITE, 1'b1);
        @(negedge PCLK);
        check("t1_access_psel", PSEL, 1'b1);
        check("t1_access_penable", PENABLE, 1'b1);
        @(negedge PCLK);
        check("t1_done_psel", PSEL, 1'b0);
        check("t1_done_penable", PENABLE, 1'b0);
        check("t1_done_rsp_valid", rsp_valid, 1'b1);
        check("t1_paddr_held", PADDR, 8'h10);

        // ---------------- 2: read with 3 wait cycles ----------------
        @(negedge PCLK);
        PREADY = 1'b0;
        PRDATA = 32'hBAD0BAD0;
        push_exp(1'b0, 32'hCAFE0001, 1'b0);
        send_cmd(1'b0, 8'h22, 32'h55555555, 4'd3);
        cfg_wait = 4'd7;
        check("t2_setup_pwait", PWAIT, 4'd3);
        check("t2_setup_paddr", PADDR, 8'h22);
        check("t2_setup_pwrite", PWRITE, 1'b0);
        check("t2_setup_pwdata_zero", PWDATA, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge PCLK);
            check("t2_in_access", {PSEL, PENABLE}, 2'b11);
            check("t2_access_pwait", PWAIT, 4'd3);
            if (k == 4) begin
                PREADY = 1'b1;
                PRDATA = 32'hCAFE0001;
            end
        end
        @(negedge PCLK);
        check("t2_access_ended", PSEL, 1'b0);
        check("t2_rsp_valid", rsp_valid, 1'b1);

        // ---------------- 3: back-to-back commands ----------------
        @(negedge PCLK);
        PREADY = 1'b1;
        PRDATA = 32'h0BADF00D;
        setup_q.delete();
        push_exp(1'b1, 32'h0, 1'b0);
        push_exp(1'b0, 32'h0BADF00D, 1'b0);
        send_cmd(1'b1, 8'h40, 32'hA5A5A5A5, 4'd1);
        send_cmd(1'b0, 8'h41, 32'h0, 4'd2);
        repeat (3) @(negedge PCLK);
        check("t3_setup_count", setup_q.size(), 2);
        if (setup_q.size() >= 2) begin
            s0 = setup_q[0];
            check("t3_setup_spacing", setup_q[1] - s0, 3);
            check("t3_psel_gap", psel_at[s0 + 2], 1'b0);
        end

        // ---------------- 4: response back-pressure ----------------
        @(negedge PCLK);
        rsp_ready = 1'b0;
        PREADY = 1'b1;
        PRDATA = 32'h12345678;
        push_exp(1'b0, 32'h12345678, 1'b0);
        send_cmd(1'b0, 8'h30, 32'h0, 4'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRDATA = 32'hFFFF0000;
        push_exp(1'b1, 32'h0, 1'b0);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h44;
        cmd_wdata = 32'h0F0F0F0F;
        cfg_wait  = 4'd5;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge PCLK);
            #1;
            check("t4_hold_valid", rsp_valid, 1'b1);
            check("t4_hold_rdata", rsp_rdata, 32'h12345678);
            check("t4_hold_write", rsp_write, 1'b0);
            check("t4_blocked_ready", cmd_ready, 1'b0);
            check("t4_no_psel", PSEL, 1'b0);
        end
        @(negedge PCLK);
        rsp_ready = 1'b1;
        #1;
        check("t4_ready_on_drain", cmd_ready, 1'b1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        check("t4_setup_psel", {PSEL, PENABLE}, 2'b10);
        check("t4_setup_paddr", PADDR, 8'h44);
        check("t4_setup_pwait", PWAIT, 4'd5);
        @(negedge PCLK);
        @(negedge PCLK);

        // ---------------- 5: reset during ACCESS ----------------
        @(negedge PCLK);
        PREADY = 1'b0;
        send_cmd(1'b0, 8'h50, 32'h0, 4'd0);
        @(negedge PCLK);
        check("t5_in_access", {PSEL, PENABLE}, 2'b11);
        #2;
        PRESET = 1'b0;
        #1;
        check("t5_rst_psel", PSEL, 1'b0);
        check("t5_rst_penable", PENABLE, 1'b0);
        check("t5_rst_rsp_valid", rsp_valid, 1'b0);
        check("t5_rst_cmd_ready", cmd_ready, 1'b0);
        @(negedge PCLK);
        PRESET = 1'b1;
        PREADY = 1'b1;
        repeat (4) @(negedge PCLK);
        check("t5_no_stale_rsp", rsp_valid, 1'b0);
        push_exp(1'b1, 32'h0, 1'b0);
        send_cmd(1'b1, 8'h60, 32'h600DCAFE, 4'd0);
        check("t5_new_pwdata", PWDATA, 32'h600DCAFE);
        @(negedge PCLK);
        @(negedge PCLK);
        check("t5_new_rsp_valid", rsp_valid, 1'b1);

        // ---------------- 6: slave never ready ----------------
        @(negedge PCLK);
        PREADY = 1'b0;
        PRDATA = 32'h77777777;
`ifdef APB_MASTER_TIMEOUT_EN
        push_exp(1'b0, 32'h0, 1'b1);
        send_cmd(1'b0, 8'h70, 32'h0, 4'd0);
        n_acc = 0;
        @(negedge PCLK);
        while (PSEL && PENABLE && n_acc < 50) begin
            n_acc++;
            @(negedge PCLK);
        end
        check("t6_access_cycles", n_acc, TO_CYC);
        check("t6_abort_psel", PSEL, 1'b0);
        check("t6_abort_rsp_valid", rsp_valid, 1'b1);
        check("t6_abort_rsp_err", rsp_err, 1'b1);
        check("t6_abort_rsp_rdata", rsp_rdata, 32'h0);
`else
        push_exp(1'b0, 32'h77777777, 1'b0);
        send_cmd(1'b0, 8'h70, 32'h0, 4'd0);
        repeat (100) @(negedge PCLK);
        check("t6_still_access", {PSEL, PENABLE}, 2'b11);
        check("t6_no_rsp", rsp_valid, 1'b0);
        PREADY = 1'b1;
        @(negedge PCLK);
        check("t6_late_rsp_valid", rsp_valid, 1'b1);
        check("t6_late_rsp_err", rsp_err, 1'b0);
`endif

        // ---------------- drain scoreboard ----------------
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge PCLK);
            budget++;
        end
        repeat (2) @(negedge PCLK);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that drives the APB slave ports (PSEL, PENABLE, PADDR, PWRITE, PWDATA, PWAIT) and samples PREADY/PRDATA.
- Converts a valid/ready command stream from a host or test sequencer into single APB read/write transfers.
- Returns one response per command on a valid/ready response channel.
- Sits between the system-side requester and the APB memory slave; one transfer outstanding at a time.

Parameters:
ADDR_W, 8, width of PADDR/cmd_addr
DATA_W, 32, width of PWDATA/PRDATA/cmd_wdata/rsp_rdata
WAIT_W, 4, width of PWAIT/cfg_wait
TIMEOUT_CYC, 64, max ACCESS cycles without PREADY; used only with APB_MASTER_TIMEOUT_EN

Ports:
PCLK  in  1  clock, rising edge
PRESET  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data (ignored for reads)
cfg_wait  in  WAIT_W  wait-cycle count forwarded to slave on PWAIT
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PWAIT  out  WAIT_W  slave wait configuration
PREADY  in  1  slave ready
PRDATA  in  DATA_W  slave read data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_write  out  1  direction of completed transfer
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  transfer aborted (timeout); 0 without APB_MASTER_TIMEOUT_EN

Behaviour:
- Reset (PRESET low, async): state IDLE; all APB outputs 0; rsp_valid, rsp_write, rsp_rdata, rsp_err 0; timeout counter 0; cmd_ready 0 while PRESET low.
- All APB and rsp_* outputs are registered.
- cmd_ready = PRESET & (state==IDLE) & (!rsp_valid | rsp_ready). This is the only combinational output.
- States: IDLE, SETUP, ACCESS.
- IDLE -> SETUP on accept.
  - On the accepting edge: PADDR<=cmd_addr, PWRITE<=cmd_write, PWDATA<=(cmd_write ? cmd_wdata : 0), PWAIT<=cfg_wait, PSEL<=1, PENABLE<=0.
- SETUP: exactly one cycle; next edge PENABLE<=1 -> ACCESS.
- ACCESS: PSEL=PENABLE=1; PADDR/PWRITE/PWDATA/PWAIT held stable; PREADY sampled each edge.
  - PREADY=1 at edge: PSEL<=0, PENABLE<=0, rsp_valid<=1, rsp_write<=PWRITE, rsp_rdata<=(PWRITE ? 0 : PRDATA), rsp_err<=0 -> IDLE.
  - PREADY=0: stay in ACCESS indefinitely (base build).
- PADDR/PWRITE/PWDATA/PWAIT keep their last values after a transfer until the next accept.
- Response channel:
  - rsp_* held stable while rsp_valid & !rsp_ready.
  - rsp_valid clears on handshake unless a new response loads the same edge; loading takes priority.
- Minimum throughput: 3 cycles per transfer (accept, SETUP, ACCESS-with-PREADY). Back-to-back accept is allowed in the cycle a response handshake occurs.
- PREADY, PRDATA are ignored outside ACCESS.
- cfg_wait changes during a transfer have no effect until the next accept.
- Reset mid-transfer: PSEL/PENABLE drop immediately (async); the in-flight command and any pending response are discarded.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined: a cycle counter clears on SETUP->ACCESS and increments each ACCESS cycle with PREADY=0. When the counter == TIMEOUT_CYC-1 and PREADY=0, the next edge does all of the following, then returns to IDLE:
  - abort: PSEL<=0, PENABLE<=0
  - rsp_valid<=1, rsp_err<=1, rsp_rdata<=0, rsp_write<=PWRITE
- PREADY=1 in the same cycle as the limit wins: normal completion, rsp_err=0.
- Undefined: no counter logic; rsp_err constant 0; ACCESS waits forever.

Test Plan:
1. Write 0x10/0xDEADBEEF, cfg_wait=0, PREADY=1 in first ACCESS cycle. Expected:
   - accept at cycle 0; cycle 1 PSEL=1, PENABLE=0, PADDR=0x10, PWDATA=0xDEADBEEF, PWRITE=1
   - cycle 2 PENABLE=1
   - cycle 3 rsp_valid=1, rsp_write=1, rsp_rdata=0, PSEL=0
2. Read 0x22, cfg_wait=3, PREADY low 3 ACCESS cycles then high with PRDATA=0xCAFE0001. Expected:
   - PWAIT=3 throughout
   - ACCESS lasts 4 cycles
   - rsp_rdata=0xCAFE0001, rsp_write=0, rsp_err=0
3. Two commands queued, rsp_ready tied 1. Expected:
   - second SETUP begins exactly 3 cycles after first SETUP
   - PSEL deasserts 1 cycle between transfers
   - responses delivered in order
4. rsp_ready=0 for 5 cycles after a read completes. Expected:
   - rsp_* stable for 5 cycles
   - cmd_ready=0, no new PSEL
   - accept occurs in the cycle rsp_ready rises
5. PRESET low during ACCESS. Expected:
   - PSEL, PENABLE, rsp_valid=0 immediately
   - after release, no response for the aborted command
   - a new write completes normally
6. APB_MASTER_TIMEOUT_EN, TIMEOUT_CYC=8, PREADY held 0. Expected:
   - exactly 8 ACCESS cycles
   - then PSEL=0, rsp_valid=1, rsp_err=1, rsp_rdata=0
   - without the macro: still in ACCESS after 100 cycles
